// File: rtl/ssvep_pkg.sv
// ssvep_pkg: shared definitions for the synthetic SSVEP stimulus generator.
//   - state_e        : burst FSM states (idle / tone on / tone off)
//   - SAT_MAX/SAT_MIN: 24-bit signed output range
//   - LFSR_SEED/TAPS : noise LFSR x^16+x^14+x^13+x^11+1 (right-shift Fibonacci form)
//   - lfsr_next()    : one LFSR step
//   - sat24()        : clamp a 26-bit signed sum to the 24-bit range
package ssvep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic signed [23:0] SAT_MAX = 24'sh7FFFFF;
  localparam logic signed [23:0] SAT_MIN = 24'sh800000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16+x^14+x^13+x^11 seen from the shift-out end: bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int Q_REF_DEFAULT = 16;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  function automatic logic [23:0] sat24(input logic signed [25:0] v);
    logic signed [25:0] hi;
    logic signed [25:0] lo;
    hi = {{2{SAT_MAX[23]}}, SAT_MAX};
    lo = {{2{SAT_MIN[23]}}, SAT_MIN};
    if (v > hi) begin
      return SAT_MAX;
    end else if (v < lo) begin
      return SAT_MIN;
    end else begin
      return v[23:0];
    end
  endfunction

endpackage

// File: rtl/ssvep_stim_synth_sine_lut.sv
// sine_lut: one-period signed sine table with a registered read port.
//   clk, rst_i : clock, asynchronous active-high reset
//   addr_i     : table index 0..M-1
//   data_o     : round((2^(Q_ref-1)-1)*sin(2*pi*addr/M)), valid one cycle after addr_i
module sine_lut
  import ssvep_pkg::*;
#(
  parameter int M     = 64,
  parameter int Q_ref = Q_REF_DEFAULT,
  localparam int AW   = $clog2(M)
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic [AW-1:0]           addr_i,
  output logic signed [Q_ref-1:0] data_o
);

  // Elaboration-time sine via a Taylor series on an angle folded into [-pi, pi];
  // 13 terms keep the error far below half an LSB at 16 bits.
  function automatic int sine_word(input int k);
    real pi;
    real ang;
    real term;
    real acc;
    real scaled;
    pi  = 3.14159265358979323846;
    ang = 2.0 * pi * real'(k) / real'(M);
    if (ang > pi) begin
      ang = ang - 2.0 * pi;
    end else begin
      ang = ang + 0.0;
    end
    term = ang;
    acc  = ang;
    for (int n = 1; n < 14; n++) begin
      term = -term * ang * ang / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    scaled = acc * real'((1 << (Q_ref - 1)) - 1);
    if (scaled >= 0.0) begin
      return $rtoi(scaled + 0.5);
    end else begin
      return -$rtoi(0.5 - scaled);
    end
  endfunction

  logic signed [Q_ref-1:0] rom [M];

  for (genvar k = 0; k < M; k++) begin : g_rom
    localparam int V = sine_word(k);
    assign rom[k] = V[Q_ref-1:0];
  end

  logic signed [Q_ref-1:0] data_q;

  // Registered table read.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= rom[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/ssvep_stim_synth.sv
// ssvep_stim_synth: paced synthetic SSVEP sample source (sine + DC + LFSR noise,
// gated in ON/OFF bursts).
//   clk, reset   : system clock, asynchronous active-high reset
//   enable       : run request, looked at only on sample ticks
//   amplitude    : unsigned sine amplitude (LSBs)
//   offset       : signed 24-bit DC offset
//   noise_shift  : noise attenuation, >=16 removes noise
//   x / x_valid  : signed sample (24-bit saturated, sign-extended) and its strobe
//   sync         : strobe with x_valid for index 0 of every ON period
//   burst_on     : high while the burst FSM is ON
// Pipeline: tick edge -> (1) LUT read + input capture -> (2) multiply -> (3) sum/sat/out.
module ssvep_stim_synth
  import ssvep_pkg::*;
#(
  parameter int Q_out   = 32,
  parameter int Q_ref   = Q_REF_DEFAULT,
  parameter int M       = 64,
  parameter int CLK_DIV = 50000,
  parameter int N_on    = 8,
  parameter int N_off   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [15:0]      amplitude,
  input  logic [23:0]      offset,
  input  logic [4:0]       noise_shift,
  output logic [Q_out-1:0] x,
  output logic             x_valid,
  output logic             sync,
  output logic             burst_on
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(M);
  localparam int PER_W = $clog2(((N_on > N_off) ? N_on : N_off) + 1);

  // ---------------- divider, FSM, counters, LFSR ----------------
  logic [DIV_W-1:0] div_q;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             burst_q;

  logic tick_s;
  logic emit_s;
  logic mode_on_s;
  logic last_idx_s;

  assign tick_s     = (div_q == DIV_W'(CLK_DIV - 1));
  assign emit_s     = tick_s & enable;
  // The entry tick out of IDLE already emits a tone sample.
  assign mode_on_s  = (state_q != ST_OFF);
  assign last_idx_s = (idx_q == IDX_W'(M - 1));

  // Free-running sample-tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick_s) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Burst FSM next state, phase/period counters and LFSR advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    per_d   = per_q;
    lfsr_d  = lfsr_q;
    if (tick_s) begin
      if (!enable) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        per_d   = '0;
      end else begin
        lfsr_d = lfsr_next(lfsr_q);
        idx_d  = last_idx_s ? '0 : idx_q + IDX_W'(1);
        case (state_q)
          ST_IDLE, ST_ON: begin
            state_d = ST_ON;
            if (last_idx_s) begin
              if (per_q == PER_W'(N_on - 1)) begin
                per_d = '0;
                if (N_off != 0) begin
                  state_d = ST_OFF;
                end else begin
                  state_d = ST_ON;
                end
              end else begin
                per_d = per_q + PER_W'(1);
              end
            end else begin
              per_d = per_q;
            end
          end
          ST_OFF: begin
            state_d = ST_OFF;
            if (last_idx_s) begin
              if (per_q == PER_W'(N_off - 1)) begin
                per_d   = '0;
                state_d = ST_ON;
              end else begin
                per_d = per_q + PER_W'(1);
              end
            end else begin
              per_d = per_q;
            end
          end
          default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            per_d   = '0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM/counter/LFSR state registers and registered burst flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      per_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      lfsr_q  <= lfsr_d;
      burst_q <= (state_d == ST_ON);
    end
  end

  // ---------------- stage 1: LUT read and input capture ----------------
  logic signed [Q_ref-1:0] lut_data_s;
  logic                    v1_q, sync1_q, on1_q;
  logic [15:0]             amp1_q;
  logic signed [23:0]      off1_q;
  logic [4:0]              ns1_q;
  logic [15:0]             lfsr1_q;

  sine_lut #(
    .M     (M),
    .Q_ref (Q_ref)
  ) u_lut (
    .clk    (clk),
    .rst_i  (reset),
    .addr_i (idx_q),
    .data_o (lut_data_s)
  );

  // Capture the tick's inputs alongside the LUT read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      sync1_q <= 1'b0;
      on1_q   <= 1'b0;
      amp1_q  <= '0;
      off1_q  <= '0;
      ns1_q   <= '0;
      lfsr1_q <= '0;
    end else begin
      v1_q    <= emit_s;
      sync1_q <= emit_s & mode_on_s & (idx_q == '0);
      if (emit_s) begin
        on1_q   <= mode_on_s;
        amp1_q  <= amplitude;
        off1_q  <= offset;
        ns1_q   <= noise_shift;
        lfsr1_q <= lfsr_q;
      end
    end
  end

  // ---------------- stage 2: multiply, noise scaling ----------------
  logic signed [32:0] prod_s;
  logic signed [15:0] noise_s;
  logic               v2_q, sync2_q;
  logic signed [23:0] off2_q;
  logic signed [25:0] sine2_q, noise2_q;

  assign prod_s  = $signed({17'b0, amp1_q}) * 33'(lut_data_s);
  assign noise_s = $signed(lfsr1_q) >>> ns1_q;

  // Scaled sine term (zero in OFF) and attenuated noise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_q     <= 1'b0;
      sync2_q  <= 1'b0;
      off2_q   <= '0;
      sine2_q  <= '0;
      noise2_q <= '0;
    end else begin
      v2_q    <= v1_q;
      sync2_q <= sync1_q;
      if (v1_q) begin
        off2_q   <= off1_q;
        sine2_q  <= on1_q ? 26'(prod_s >>> (Q_ref - 1)) : 26'sd0;
        noise2_q <= (ns1_q >= 5'd16) ? 26'sd0 : 26'(noise_s);
      end
    end
  end

  // ---------------- stage 3: sum, saturate, output ----------------
  logic signed [25:0] sum_s;
  logic [Q_out-1:0]   x_q;
  logic               x_valid_q, sync_q;

  assign sum_s = 26'(off2_q) + sine2_q + noise2_q;

  // Output register; x holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      x_valid_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      x_valid_q <= v2_q;
      sync_q    <= sync2_q;
      if (v2_q) begin
        x_q <= Q_out'($signed(sat24(sum_s)));
      end
    end
  end

  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign sync     = sync_q;
  assign burst_on = burst_q;

endmodule

// File: tb/tb_ssvep_stim_synth.sv
module tb_ssvep_stim_synth;

  localparam int M       = 16;
  localparam int CLK_DIV = 8;
  localparam int N_on    = 2;
  localparam int N_off   = 1;
  localparam int CYC_LEN = M * (N_on + N_off);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] amplitude = 16'd0;
  logic [23:0] offset = 24'd0;
  logic [4:0]  noise_shift = 5'd0;
  logic [31:0] x;
  logic        x_valid, sync, burst_on;

  ssvep_stim_synth #(
    .Q_out(32), .Q_ref(16), .M(M), .CLK_DIV(CLK_DIV), .N_on(N_on), .N_off(N_off)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .amplitude(amplitude),
    .offset(offset), .noise_shift(noise_shift),
    .x(x), .x_valid(x_valid), .sync(sync), .burst_on(burst_on)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Edge counter since reset release: edge n leaves mcyc == n.
  int mcyc;
  always @(posedge clk or posedge reset) begin
    if (reset) mcyc <= 0;
    else       mcyc <= mcyc + 1;
  end

  // Strobe monitor.
  logic [31:0] obs_x [$];
  logic        obs_sync [$];
  int          obs_cyc [$];
  int          n_obs_total = 0;
  always @(negedge clk) begin
    if (!reset && x_valid) begin
      obs_x.push_back(x);
      obs_sync.push_back(sync);
      obs_cyc.push_back(mcyc);
      n_obs_total = n_obs_total + 1;
    end
  end

  typedef struct {
    logic [31:0] x;
    logic        sync;
    int          cyc;
    int          idx;
    logic        on;
  } exp_t;
  exp_t exp_q [$];

  // Reference model state: samples since the run started, and the noise LFSR.
  int          k = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic        exp_burst = 1'b0;
  int          chk_mode = 0;
  logic [31:0] tone_tab [4] = '{32'd0, 32'd999, 32'd0, 32'hFFFFFC18};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lut_ref(input int i);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(i) / real'(M));
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(0.5 - r);
  endfunction

  // Called just after a sample-capture edge with the values that were on the pins.
  task automatic model_tick(input logic en, input logic [15:0] amp, input logic [23:0] off,
                            input logic [4:0] ns);
    exp_t   e;
    int     pos, idx, sine, noise, s;
    longint prod;
    logic   on, fb;
    if (!en) begin
      k = 0;
      exp_burst = 1'b0;
    end else begin
      pos   = k % CYC_LEN;
      on    = (pos < M * N_on);
      idx   = k % M;
      prod  = longint'(amp) * longint'(lut_ref(idx));
      sine  = on ? int'(prod >>> 15) : 0;
      noise = (ns >= 5'd16) ? 0 : (int'($signed(m_lfsr)) >>> ns);
      s     = int'($signed(off)) + sine + noise;
      if (s > 8388607) s = 8388607;
      else if (s < -8388608) s = -8388608;
      e.x    = 32'(s);
      e.sync = on && (idx == 0);
      e.cyc  = mcyc + 2;
      e.idx  = idx;
      e.on   = on;
      exp_q.push_back(e);
      k  = k + 1;
      fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
      exp_burst = ((k % CYC_LEN) < M * N_on);
    end
  endtask

  task automatic check_pending();
    exp_t        e;
    int          oc, extra;
    logic [31:0] ox;
    logic        os;
    while (exp_q.size() > 0 && exp_q[0].cyc <= mcyc) begin
      e = exp_q.pop_front();
      chk("strobe_present", 32'(obs_cyc.size() > 0), 32'd1);
      if (obs_cyc.size() > 0) begin
        oc = obs_cyc.pop_front();
        ox = obs_x.pop_front();
        os = obs_sync.pop_front();
        chk("strobe_cycle", 32'(oc), 32'(e.cyc));
        chk("x", ox, e.x);
        chk("sync", 32'(os), 32'(e.sync));
        if (chk_mode == 1 && (e.idx % 4) == 0 && e.idx < 16)
          chk("tone_point", ox, tone_tab[e.idx / 4]);
        if (chk_mode == 2 && e.on && e.idx == 4)
          chk("sat_peak", ox, 32'h007FFFFF);
        if (chk_mode == 3 && e.on && e.idx == 12)
          chk("sat_trough", ox, 32'hFF800000);
      end
    end
    extra = 0;
    while (obs_cyc.size() > 0 && obs_cyc[0] <= mcyc) begin
      extra++;
      oc = obs_cyc.pop_front();
      ox = obs_x.pop_front();
      os = obs_sync.pop_front();
    end
    chk("extra_strobes", 32'(extra), 32'd0);
  endtask

  // One sample slot: junk on the inputs between ticks, the real values just
  // before the capture edge, then model update and burst flag check.
  task automatic run_slot(input logic en, input logic [15:0] amp, input logic [23:0] off,
                          input logic [4:0] ns);
    for (int j = 1; j <= 7; j++) begin
      step();
      if (j == 2) begin
        enable      = 1'($urandom_range(0, 1));
        amplitude   = 16'($urandom);
        offset      = 24'($urandom);
        noise_shift = 5'($urandom);
      end
      if (j == 3) check_pending();
    end
    enable      = en;
    amplitude   = amp;
    offset      = off;
    noise_shift = ns;
    step();
    model_tick(en, amp, off, ns);
    chk("burst_on", 32'(burst_on), 32'(exp_burst));
  endtask

  task automatic rand_slot(input logic en);
    logic [4:0] ns;
    ns = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
    run_slot(en, 16'($urandom), 24'($urandom), ns);
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    repeat (3) step();
    chk("rst_x", x, 32'd0);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_burst_on", 32'(burst_on), 32'd0);
    reset = 1'b0;

    // Idle after release: no strobes, x stays 0, LFSR untouched.
    for (int i = 0; i < 10; i++) rand_slot(1'b0);
    check_pending();
    chk("idle_x", x, 32'd0);
    chk("idle_strobes", 32'(n_obs_total), 32'd0);
    chk("idle_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);

    // Pure noise from the seed.
    for (int i = 0; i < 5; i++) run_slot(1'b1, 16'd0, 24'd0, 5'd0);
    run_slot(1'b0, 16'd0, 24'd0, 5'd0);

    // Pure tone.
    chk_mode = 1;
    for (int i = 0; i < 18; i++) run_slot(1'b1, 16'd1000, 24'd0, 5'd16);
    run_slot(1'b0, 16'd1000, 24'd0, 5'd16);

    // Saturation, high then low.
    chk_mode = 2;
    for (int i = 0; i < 9; i++) run_slot(1'b1, 16'hFFFF, 24'h7FFFF0, 5'd16);
    run_slot(1'b0, 16'd0, 24'd0, 5'd16);
    chk_mode = 3;
    for (int i = 0; i < 14; i++) run_slot(1'b1, 16'hFFFF, 24'h800010, 5'd16);
    run_slot(1'b0, 16'd0, 24'd0, 5'd16);
    chk_mode = 0;

    // Bursts with randomized inputs across several ON/OFF cycles.
    for (int i = 0; i < 2 * CYC_LEN + 20; i++) rand_slot(1'b1);

    // Enable drop at sample 5, then restart.
    run_slot(1'b0, 16'd0, 24'd0, 5'd16);
    for (int i = 0; i < 5; i++) rand_slot(1'b1);
    for (int i = 0; i < 3; i++) rand_slot(1'b0);
    for (int i = 0; i < 20; i++) rand_slot(1'b1);

    // Reset with a sample in flight.
    reset = 1'b1;
    repeat (2) step();
    exp_q.delete();
    obs_x.delete();
    obs_sync.delete();
    obs_cyc.delete();
    k = 0;
    m_lfsr = 16'hACE1;
    exp_burst = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) rand_slot(1'b1);
    for (int i = 0; i < 2; i++) rand_slot(1'b0);
    check_pending();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
